// File: rtl/mem_arbiter.sv
// Fetch/data arbiter sharing one single-port word memory, one access per cycle.
// Optional anti-starvation burst limit: define MEM_ARB_ANTI_STARVE_EN.
module mem_arbiter #(
    parameter int unsigned MEM_AW         = 10,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [31:0]       if_addr_i,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic              d_we_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    input  logic [3:0]        d_be_i,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_IF,
        OWN_D
    } owner_t;

    owner_t owner_q;
    logic   err_q;
    logic   store_q;
    logic   d_misaligned;
    logic   force_if;
    logic   gnt_d;
    logic   gnt_if;
    logic   unused_addr_bits;

    // Partial-byte stores may sit at any byte offset; full-word and load accesses may not.
    assign d_misaligned = (d_addr_i[1:0] != 2'b00) && (!d_we_i || (d_be_i == 4'hF));

    assign unused_addr_bits = ^{if_addr_i[31:MEM_AW+2], if_addr_i[1:0], d_addr_i[31:MEM_AW+2]};

`ifdef MEM_ARB_ANTI_STARVE_EN
    logic [3:0] starve_cnt_q;

    assign force_if = if_req_valid_i && (starve_cnt_q == 4'(MAX_DATA_BURST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else if (!if_req_valid_i || gnt_if) begin
            starve_cnt_q <= '0;
        end else if (gnt_d && (starve_cnt_q != 4'(MAX_DATA_BURST))) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Grants are gated by reset so nothing is accepted while rst_ni is low.
    always_comb begin
        gnt_d          = rst_ni && d_req_valid_i && !force_if;
        gnt_if         = rst_ni && if_req_valid_i && !gnt_d;
        if_req_ready_o = gnt_if;
        d_req_ready_o  = gnt_d;
        mem_en_o       = gnt_if || (gnt_d && !d_misaligned);
        mem_we_o       = gnt_d && d_we_i && !d_misaligned;
        mem_addr_o     = gnt_d ? d_addr_i[MEM_AW+1:2] : if_addr_i[MEM_AW+1:2];
        mem_wdata_o    = d_wdata_i;
        mem_be_o       = mem_we_o ? d_be_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_IDLE;
            err_q   <= 1'b0;
            store_q <= 1'b0;
        end else if (gnt_d) begin
            owner_q <= OWN_D;
            err_q   <= d_misaligned;
            store_q <= d_we_i;
        end else if (gnt_if) begin
            owner_q <= OWN_IF;
            err_q   <= 1'b0;
            store_q <= 1'b0;
        end else begin
            owner_q <= OWN_IDLE;
            err_q   <= 1'b0;
            store_q <= 1'b0;
        end
    end

    always_comb begin
        if_rvalid_o = (owner_q == OWN_IF);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rvalid_o  = (owner_q == OWN_D);
        d_err_o     = d_rvalid_o && err_q;
        d_rdata_o   = (d_rvalid_o && !err_q && !store_q) ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory.
// Grant-pattern expectations follow MEM_ARB_ANTI_STARVE_EN.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        if_req_valid_i;
    logic        if_req_ready_o;
    logic [31:0] if_addr_i;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_valid_i;
    logic        d_req_ready_o;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [1024];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [9:0]  d_pat;

    mem_arbiter #(.MEM_AW(10), .MAX_DATA_BURST(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
        .if_addr_i(if_addr_i), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o),
        .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: byte-enabled writes, one-cycle read latency.
    always @(posedge clk_i) begin
        if (!rst_ni) begin
            mem[0]      <= 32'h11;
            mem[1]      <= 32'h22;
            mem[2]      <= 32'h33;
            mem_rdata_i <= '0;
        end else if (mem_en_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end else if (mem_en_o) begin
            mem_rdata_i <= mem[mem_addr_o];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic ifv, input logic [31:0] ifa, input logic dv,
                          input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                          input logic [3:0] dbe);
        if_req_valid_i = ifv;
        if_addr_i      = ifa;
        d_req_valid_i  = dv;
        d_we_i         = dwe;
        d_addr_i       = da;
        d_wdata_i      = dwd;
        d_be_i         = dbe;
        #1;
    endtask

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
`ifdef MEM_ARB_ANTI_STARVE_EN
        d_pat = 10'b0111101111;
`else
        d_pat = 10'b1111111111;
`endif
        // Reset with both requesters asserting valid.
        rst_ni = 1'b0;
        #1;
        set_in(1'b1, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234, 4'hF);
        check("rst_if_ready", 32'(if_req_ready_o), 32'd0);
        check("rst_d_ready", 32'(d_req_ready_o), 32'd0);
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
        check("rst_d_err", 32'(d_err_o), 32'd0);
        check("rst_if_rdata", if_rdata_o, 32'd0);
        check("rst_d_rdata", d_rdata_o, 32'd0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        idle();
        check("idle_mem_en", 32'(mem_en_o), 32'd0);

        // Sequential fetches 0x0, 0x4, 0x8.
        next_cycle();
        set_in(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, '0);
        check("f0_ready", 32'(if_req_ready_o), 32'd1);
        check("f0_addr", 32'(mem_addr_o), 32'd0);
        check("f0_rvalid", 32'(if_rvalid_o), 32'd0);
        next_cycle();
        set_in(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, '0);
        check("f1_addr", 32'(mem_addr_o), 32'd1);
        check("f1_rvalid", 32'(if_rvalid_o), 32'd1);
        check("f1_rdata", if_rdata_o, 32'h11);
        next_cycle();
        set_in(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, '0);
        check("f2_addr", 32'(mem_addr_o), 32'd2);
        check("f2_rdata", if_rdata_o, 32'h22);
        next_cycle();
        idle();
        check("f3_rvalid", 32'(if_rvalid_o), 32'd1);
        check("f3_rdata", if_rdata_o, 32'h33);
        check("f3_mem_en", 32'(mem_en_o), 32'd0);
        next_cycle();
        idle();
        check("f4_rvalid", 32'(if_rvalid_o), 32'd0);

        // Both ports continuously valid.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, '0, '0);
            check($sformatf("burst_d_ready%0d", i), 32'(d_req_ready_o), 32'(d_pat[i]));
            check($sformatf("burst_if_ready%0d", i), 32'(if_req_ready_o), 32'(!d_pat[i]));
        end
        next_cycle();
        idle();

        // Store then load at 0x40.
        next_cycle();
        set_in(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        check("st_ready", 32'(d_req_ready_o), 32'd1);
        check("st_mem_en", 32'(mem_en_o), 32'd1);
        check("st_mem_we", 32'(mem_we_o), 32'd1);
        check("st_addr", 32'(mem_addr_o), 32'h10);
        check("st_wdata", mem_wdata_o, 32'hDEADBEEF);
        next_cycle();
        set_in(1'b0, '0, 1'b1, 1'b0, 32'h40, '0, '0);
        check("ld_addr", 32'(mem_addr_o), 32'h10);
        check("ld_mem_we", 32'(mem_we_o), 32'd0);
        check("st_ack_rvalid", 32'(d_rvalid_o), 32'd1);
        check("st_ack_rdata", d_rdata_o, 32'd0);
        check("st_ack_err", 32'(d_err_o), 32'd0);
        next_cycle();
        idle();
        check("ld_rvalid", 32'(d_rvalid_o), 32'd1);
        check("ld_rdata", d_rdata_o, 32'hDEADBEEF);

        // Misaligned load.
        next_cycle();
        set_in(1'b0, '0, 1'b1, 1'b0, 32'h41, '0, '0);
        check("mis_ready", 32'(d_req_ready_o), 32'd1);
        check("mis_mem_en", 32'(mem_en_o), 32'd0);
        next_cycle();
        // Partial store at byte offset 2 is legal.
        set_in(1'b0, '0, 1'b1, 1'b1, 32'h42, 32'hABCD0000, 4'b1100);
        check("mis_rvalid", 32'(d_rvalid_o), 32'd1);
        check("mis_err", 32'(d_err_o), 32'd1);
        check("mis_rdata", d_rdata_o, 32'd0);
        check("pst_mem_en", 32'(mem_en_o), 32'd1);
        check("pst_be", 32'(mem_be_o), 32'hC);
        next_cycle();
        // Upper address bits wrap.
        set_in(1'b0, '0, 1'b1, 1'b0, 32'h1000_0040, '0, '0);
        check("pst_err", 32'(d_err_o), 32'd0);
        check("wrap_addr", 32'(mem_addr_o), 32'h10);
        next_cycle();
        idle();
        check("wrap_rdata", d_rdata_o, 32'hABCDBEEF);

        // Reset mid-access, after building up data grants.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h8, '0, '0);
            check($sformatf("pre_rst_d_ready%0d", i), 32'(d_req_ready_o), 32'd1);
        end
        next_cycle();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
        check("mid_rst_d_rdata", d_rdata_o, 32'd0);
        check("mid_rst_d_ready", 32'(d_req_ready_o), 32'd0);
        check("mid_rst_mem_en", 32'(mem_en_o), 32'd0);
        next_cycle();
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            set_in(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, '0, '0);
            if (i == 0) check("post_rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
            check($sformatf("post_rst_d_ready%0d", i), 32'(d_req_ready_o), 32'(d_pat[i]));
        end
        next_cycle();
        idle();
        next_cycle();
        idle();

        // Data load then fetch on consecutive cycles.
        next_cycle();
        set_in(1'b0, '0, 1'b1, 1'b0, 32'h4, '0, '0);
        check("il_d_ready", 32'(d_req_ready_o), 32'd1);
        next_cycle();
        set_in(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, '0);
        check("il_if_ready", 32'(if_req_ready_o), 32'd1);
        check("il_d_rvalid", 32'(d_rvalid_o), 32'd1);
        check("il_d_rdata", d_rdata_o, 32'h22);
        check("il_if_rvalid0", 32'(if_rvalid_o), 32'd0);
        next_cycle();
        idle();
        check("il_if_rvalid", 32'(if_rvalid_o), 32'd1);
        check("il_if_rdata", if_rdata_o, 32'h33);
        check("il_d_rvalid1", 32'(d_rvalid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
